// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//   Bimodal branch predictor: a table of ENTRIES 2-bit saturating history
//   counters indexed by pc[log2(ENTRIES)+1:2]. The fetch stage reads a
//   combinational prediction. The EX stage resolves conditional branches,
//   trains the table, and raises a registered one-cycle flush with the
//   corrected fetch PC whenever the carried prediction was wrong.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   if_pc_i               fetch PC for lookup
//   pred_taken_o          prediction for if_pc_i (counter bit 1)
//   ex_valid_i            EX holds a valid instruction
//   ex_is_branch_i        EX instruction is a conditional branch
//   ex_funct3_i           branch funct3
//   ex_pc_i, ex_target_i  EX instruction PC and computed branch target
//   ex_pred_taken_i       prediction carried down with the EX instruction
//   BrEq_i, BrLt_i        branch comparator results
//   stall_i               EX held this cycle
//   BrUn_o                unsigned-compare select (BLTU/BGEU)
//   flush_o               one-cycle flush pulse
//   redirect_pc_o         correct fetch PC, valid while flush_o=1
//   mispredict_cnt_o      saturating mispredict count

module branch_predictor_bht #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic        BrEq_i,
  input  logic        BrLt_i,
  input  logic        stall_i,
  output logic        BrUn_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [1:0]       bht_q [ENTRIES];
  logic [1:0]       bht_d [ENTRIES];
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             f3_valid;
  logic             taken;
  logic             resolve;
  logic             mispredict;

  // PC bits outside the index field do not take part in lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0]};

  assign rd_idx = if_pc_i[IDX_W+1:2];
  assign wr_idx = ex_pc_i[IDX_W+1:2];

  // Lookup reads the registered table, so a same-cycle update to the same
  // index is not visible until the next cycle.
  assign pred_taken_o     = bht_q[rd_idx][1];
  assign BrUn_o           = ex_funct3_i[2] & ex_funct3_i[1];
  assign flush_o          = flush_q;
  assign redirect_pc_o    = redirect_q;
  assign mispredict_cnt_o = cnt_q;

  always_comb begin
    // funct3 010/011 are not conditional branches.
    f3_valid = (ex_funct3_i[2:1] != 2'b01);

    taken = 1'b0;
    case (ex_funct3_i)
      3'b000:         taken = BrEq_i;
      3'b001:         taken = ~BrEq_i;
      3'b100, 3'b110: taken = BrLt_i;
      3'b101, 3'b111: taken = ~BrLt_i;
      default:        taken = 1'b0;
    endcase

    // While a flush is out, the EX instruction is on the wrong path.
    resolve    = ex_valid_i & ex_is_branch_i & ~stall_i & ~flush_q & f3_valid;
    mispredict = resolve & (taken != ex_pred_taken_i);

    bht_d = bht_q;
    if (resolve) begin
      if (taken) begin
        if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
      end
    end

    flush_d    = mispredict;
    redirect_d = redirect_q;
    if (mispredict) redirect_d = taken ? ex_target_i : (ex_pc_i + 32'd4);

    cnt_d = cnt_q;
    if (mispredict && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      cnt_q      <= '0;
    end else begin
      bht_q      <= bht_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
